cdb_issue_scheduler: RTL

//  Central issue scheduler for the Tomasulo back end: picks at most one of the INT/MULT/DIV/MEM issue queues per cycle.

---
 rtl/cdb_issue_scheduler_pkg.sv | 17 +
 rtl/cdb_issue_scheduler_arb.sv | 43 ++++
 rtl/cdb_issue_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/cdb_issue_scheduler_pkg.sv
// Shared types and constants for the CDB issue scheduler.
package cdb_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_MEM  = 2'd3
    } cdb_unit_e;

    localparam int unsigned NUM_ISSUE_UNITS = 4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdb_issue_scheduler_arb.sv
// Four-way round-robin arbiter; the pointer advances past the winner only on a grant.
module rr_arbiter4
    import cdb_issue_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt
);

    logic [1:0] rr_ptr;
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;

    // Pick the first requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sel   = rr_ptr;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_ISSUE_UNITS; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (found) begin
            gnt[sel] = 1'b1;
        end
    end

    // Move priority to the unit after the winner; hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= sel + 2'd1;
        end
    end

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Central issue scheduler: grants at most one unit per cycle so that results never collide on the CDB.
module cdb_issue_scheduler
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int unsigned INT_LAT  = 1,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 8,
    parameter int unsigned MEM_LAT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_rdy,
    input  logic       mult_rdy,
    input  logic       div_rdy,
    input  logic       mem_rdy,
    input  logic       mem_is_store,
    output logic       int_issue,
    output logic       mult_issue,
    output logic       div_issue,
    output logic       mem_issue,
    output logic       cdb_valid,
    output logic [1:0] cdb_owner
);

    localparam int unsigned MAX_LAT = max2(max2(INT_LAT, MULT_LAT), max2(DIV_LAT, MEM_LAT));
    localparam int unsigned DIV_CW  = $clog2(DIV_LAT + 1);

    if (INT_LAT < 1 || MULT_LAT < 1 || DIV_LAT < 1 || MEM_LAT < 1 ||
        INT_LAT > MAX_LAT || MULT_LAT > MAX_LAT || DIV_LAT > MAX_LAT || MEM_LAT > MAX_LAT) begin : g_bad_lat
        $error("cdb_issue_scheduler: every latency must be in 1..MAX_LAT");
    end

    // res[k]: CDB already booked k cycles from now; own[k]: which unit booked it.
    logic [MAX_LAT:0]              res;
    cdb_unit_e                     own [0:MAX_LAT];
    logic [DIV_CW-1:0]             div_cnt;
    logic [NUM_ISSUE_UNITS-1:0]    req;
    logic [NUM_ISSUE_UNITS-1:0]    gnt;

    // A unit is eligible when it is ready and its result slot is free; stores never use the CDB.
    always_comb begin
        req             = '0;
        req[UNIT_INT]   = int_rdy  && !res[INT_LAT];
        req[UNIT_MULT]  = mult_rdy && !res[MULT_LAT];
        req[UNIT_DIV]   = div_rdy  && !res[DIV_LAT] && (div_cnt == '0);
        req[UNIT_MEM]   = mem_rdy  && (mem_is_store || !res[MEM_LAT]);
        if (!rst_n) begin
            req = '0;
        end
    end

    rr_arbiter4 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign int_issue  = gnt[UNIT_INT];
    assign mult_issue = gnt[UNIT_MULT];
    assign div_issue  = gnt[UNIT_DIV];
    assign mem_issue  = gnt[UNIT_MEM];

    assign cdb_valid  = res[0];
    assign cdb_owner  = own[0];

    // Shift the reservation window each cycle, then book the granted unit's result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                own[k] <= UNIT_INT;
            end
        end else begin
            res <= {1'b0, res[MAX_LAT:1]};
            for (int unsigned k = 0; k < MAX_LAT; k++) begin
                own[k] <= own[k+1];
            end
            own[MAX_LAT] <= UNIT_INT;
            if (gnt[UNIT_INT]) begin
                res[INT_LAT-1] <= 1'b1;
                own[INT_LAT-1] <= UNIT_INT;
            end
            if (gnt[UNIT_MULT]) begin
                res[MULT_LAT-1] <= 1'b1;
                own[MULT_LAT-1] <= UNIT_MULT;
            end
            if (gnt[UNIT_DIV]) begin
                res[DIV_LAT-1] <= 1'b1;
                own[DIV_LAT-1] <= UNIT_DIV;
            end
            if (gnt[UNIT_MEM] && !mem_is_store) begin
                res[MEM_LAT-1] <= 1'b1;
                own[MEM_LAT-1] <= UNIT_MEM;
            end
        end
    end

    // Divider busy counter: loading DIV_LAT-1 makes div_cnt reach 0 exactly DIV_LAT cycles after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (gnt[UNIT_DIV]) begin
            div_cnt <= DIV_CW'(DIV_LAT - 1);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule
